idu_hazard_ctrl: RTL and testbench

//  Issue scheduler for the decode stage. Keeps a register scoreboard of writes

---
 rtl/idu_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_idu_hazard_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_hazard_ctrl.sv
// idu_hazard_ctrl
// Decode-stage issue scheduler. A register scoreboard tracks writes still
// outstanding from long-latency ops (load/mul/div), a two-state FSM tracks
// occupancy of the non-pipelined divider, and pipe_stall holds the decode
// output flop while a RAW, WAW or divider hazard exists. A watchdog flags
// stalls that never resolve.
module idu_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int DIV_LAT  = 34,
  parameter int WDOG_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid,
  input  logic                        dec_rs1_en,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs1_addr,
  input  logic                        dec_rs2_en,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs2_addr,
  input  logic                        dec_rd_en,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rd_addr,
  input  logic                        dec_long,
  input  logic                        dec_div,
  input  logic                        pipe_flush,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd_addr,
  output logic                        pipe_stall,
  output logic                        issue,
  output logic                        div_busy,
  output logic [NUM_REGS-1:0]         sb_pending,
  output logic                        stall_timeout
);

  localparam int CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } div_state_e;

  div_state_e            r_div_state;
  div_state_e            w_div_state_nxt;
  logic [CW-1:0]         r_div_cnt;
  logic [CW-1:0]         w_div_cnt_nxt;
  logic [NUM_REGS-1:0]   r_sb;
  logic [NUM_REGS-1:0]   w_sb_nxt;
  logic [NUM_REGS-1:0]   w_wb_onehot;
  logic [NUM_REGS-1:0]   w_eff_pend;
  logic [WDOG_W-1:0]     r_wdog;
  logic [WDOG_W-1:0]     w_wdog_inc;
  logic                  r_timeout;
  logic                  w_cand;
  logic                  w_raw1;
  logic                  w_raw2;
  logic                  w_waw;
  logic                  w_divh;
  logic                  w_set_sb;

  // Hazard detection against the scoreboard as it will look after this
  // cycle's writeback, so a returning result releases its consumer at once.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    w_wb_onehot = '0;
    if (wb_valid) w_wb_onehot[wb_rd_addr] = 1'b1;
    w_eff_pend = r_sb & ~w_wb_onehot;
    w_cand     = dec_valid & ~pipe_flush;
    w_raw1     = w_cand & dec_rs1_en & (dec_rs1_addr != '0) & w_eff_pend[dec_rs1_addr];
    w_raw2     = w_cand & dec_rs2_en & (dec_rs2_addr != '0) & w_eff_pend[dec_rs2_addr];
    w_waw      = w_cand & dec_rd_en  & (dec_rd_addr  != '0) & w_eff_pend[dec_rd_addr];
    w_divh     = w_cand & dec_div & div_busy;
  end

  assign div_busy      = (r_div_state == S_BUSY);
  assign pipe_stall    = w_raw1 | w_raw2 | w_waw | w_divh;
  // Nothing leaves decode while reset is asserted, whatever the dec_* inputs.
  assign issue         = w_cand & ~pipe_stall & ~rst;
  assign sb_pending    = r_sb;
  assign stall_timeout = r_timeout;

  // Scoreboard next state: writeback clears first, a new long issue sets
  // afterwards so it wins on a shared index; x0 is never tracked.
  always_comb begin
    w_set_sb = issue & dec_long & dec_rd_en & (dec_rd_addr != '0);
    w_sb_nxt = w_eff_pend;
    if (w_set_sb) w_sb_nxt[dec_rd_addr] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_nxt;
  end

  // Divider FSM next state. The counter holds the cycles of occupancy left
  // including the current one; the issue cycle itself is the first, so the
  // FSM drops back to IDLE in time for the next div to issue exactly
  // DIV_LAT cycles after the previous one.
  always_comb begin
    w_div_state_nxt = r_div_state;
    w_div_cnt_nxt   = r_div_cnt;
    unique case (r_div_state)
      S_IDLE: begin
        if (issue && dec_div) begin
          w_div_state_nxt = S_BUSY;
          w_div_cnt_nxt   = DIV_LOAD;
        end
      end
      S_BUSY: begin
        w_div_cnt_nxt = r_div_cnt - 1'b1;
        if (w_div_cnt_nxt == '0) w_div_state_nxt = S_IDLE;
      end
      default: begin
        w_div_state_nxt = S_IDLE;
        w_div_cnt_nxt   = '0;
      end
    endcase
  end

  // Divider FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_state <= S_IDLE;
      r_div_cnt   <= '0;
    end else begin
      r_div_state <= w_div_state_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
    end
  end

  assign w_wdog_inc = r_wdog + 1'b1;

  // Stall watchdog: counts consecutive stalled cycles, saturates at all-ones
  // and latches the sticky timeout flag when it gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (!pipe_stall) begin
      r_wdog <= '0;
    end else if (r_wdog != '1) begin
      r_wdog <= w_wdog_inc;
      if (&w_wdog_inc) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// tb_idu_hazard_ctrl
// Directed scenarios for each hazard rule plus a randomized run checked
// against a cycle-count/array reference model of the issue rules.
module tb_idu_hazard_ctrl;

  localparam int DIV_LAT = 34;
  localparam int WDOG_MAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_rs1_en, dec_rs2_en, dec_rd_en, dec_long, dec_div;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_rd_addr;
  logic        pipe_flush, wb_valid;
  logic        pipe_stall, issue, div_busy, stall_timeout;
  logic [31:0] sb_pending;

  int n_tests = 0;
  int n_fail  = 0;

  idu_hazard_ctrl #(.NUM_REGS(32), .DIV_LAT(DIV_LAT), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid),
    .dec_rs1_en(dec_rs1_en), .dec_rs1_addr(dec_rs1_addr),
    .dec_rs2_en(dec_rs2_en), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
    .dec_long(dec_long), .dec_div(dec_div),
    .pipe_flush(pipe_flush),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .pipe_stall(pipe_stall), .issue(issue), .div_busy(div_busy),
    .sb_pending(sb_pending), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic drive_idle();
    dec_valid = 0; dec_rs1_en = 0; dec_rs2_en = 0; dec_rd_en = 0;
    dec_long = 0; dec_div = 0; pipe_flush = 0; wb_valid = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0; wb_rd_addr = 0;
  endtask

  // Advance one clock; inputs are then driven at posedge+1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic present_long(input logic [4:0] rd);
    drive_idle();
    dec_valid = 1; dec_rd_en = 1; dec_rd_addr = rd; dec_long = 1;
  endtask

  task automatic present_read1(input logic [4:0] rs);
    drive_idle();
    dec_valid = 1; dec_rs1_en = 1; dec_rs1_addr = rs;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    dec_valid = 1; dec_rs1_en = 1; dec_rs1_addr = 5;
    #1;
    n_tests++;
    if (pipe_stall !== 1'b0 || issue !== 1'b0 || div_busy !== 1'b0 ||
        sb_pending !== 32'h0 || stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got stall=%b issue=%b busy=%b sb=%h tmo=%b want all zero",
               pipe_stall, issue, div_busy, sb_pending, stall_timeout);
    end
    next_cycle();
    rst = 1'b0;
    drive_idle();
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    present_long(5);
    #1;
    n_tests++;
    if (issue !== 1'b1 || pipe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_issue: got issue=%b stall=%b want 1 0", issue, pipe_stall);
    end
    next_cycle();
    n_tests++;
    if (sb_pending !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL load_pending: got sb=%h want 00000020", sb_pending);
    end
    present_read1(5);
    dec_rd_en = 1; dec_rd_addr = 6;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (pipe_stall !== 1'b1 || issue !== 1'b0) begin
        n_fail++;
        $display("FAIL raw_stall[%0d]: got stall=%b issue=%b want 1 0", i, pipe_stall, issue);
      end
      next_cycle();
    end
    wb_valid = 1; wb_rd_addr = 5;
    #1;
    n_tests++;
    if (pipe_stall !== 1'b0 || issue !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release: got stall=%b issue=%b want 0 1", pipe_stall, issue);
    end
    next_cycle();
    drive_idle();
    n_tests++;
    if (sb_pending !== 32'h0) begin
      n_fail++;
      $display("FAIL wb_clear: got sb=%h want 00000000", sb_pending);
    end
  endtask

  task automatic test_x0();
    do_reset();
    present_long(0);
    #1;
    n_tests++;
    if (issue !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_issue: got issue=%b want 1", issue);
    end
    next_cycle();
    n_tests++;
    if (sb_pending !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_untracked: got sb=%h want 00000000", sb_pending);
    end
    present_read1(0);
    dec_rs2_en = 1; dec_rs2_addr = 0; dec_rd_en = 1; dec_rd_addr = 0;
    #1;
    n_tests++;
    if (pipe_stall !== 1'b0 || issue !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_read: got stall=%b issue=%b want 0 1", pipe_stall, issue);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_back_to_back_div();
    int k;
    bit issued;
    do_reset();
    drive_idle();
    dec_valid = 1; dec_div = 1; dec_rd_en = 1; dec_rd_addr = 3;
    #1;
    n_tests++;
    if (issue !== 1'b1) begin
      n_fail++;
      $display("FAIL div_first_issue: got issue=%b want 1", issue);
    end
    next_cycle();
    dec_rd_addr = 4;
    issued = 0;
    k = 1;
    while (!issued && k <= DIV_LAT + 6) begin
      #1;
      if (issue === 1'b1) begin
        issued = 1;
      end else begin
        n_tests++;
        if (div_busy !== 1'b1 || pipe_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL div_busy_stall[T+%0d]: got busy=%b stall=%b want 1 1", k, div_busy, pipe_stall);
        end
        next_cycle();
        k++;
      end
    end
    n_tests++;
    if (!issued || k != DIV_LAT) begin
      n_fail++;
      $display("FAIL div_spacing: got issued=%0d at T+%0d want issued at T+%0d", issued, k, DIV_LAT);
    end
    n_tests++;
    if (div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_gap: got busy=%b at re-entry cycle want 0", div_busy);
    end
    next_cycle();
    drive_idle();
    n_tests++;
    if (div_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div_reenter: got busy=%b want 1", div_busy);
    end
  endtask

  task automatic test_wb_and_set_same();
    do_reset();
    present_long(7);
    next_cycle();
    present_long(7);
    wb_valid = 1; wb_rd_addr = 7;
    #1;
    n_tests++;
    if (issue !== 1'b1 || pipe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL same_idx_issue: got issue=%b stall=%b want 1 0", issue, pipe_stall);
    end
    next_cycle();
    drive_idle();
    n_tests++;
    if (sb_pending !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL set_wins: got sb=%h want 00000080", sb_pending);
    end
    wb_valid = 1; wb_rd_addr = 12;
    next_cycle();
    wb_valid = 1; wb_rd_addr = 7;
    next_cycle();
    drive_idle();
    n_tests++;
    if (sb_pending !== 32'h0) begin
      n_fail++;
      $display("FAIL wb_nonpending_then_clear: got sb=%h want 00000000", sb_pending);
    end
  endtask

  task automatic test_flush();
    do_reset();
    present_long(9);
    next_cycle();
    drive_idle();
    dec_valid = 1; dec_rs2_en = 1; dec_rs2_addr = 9;
    #1;
    n_tests++;
    if (pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_stall: got stall=%b want 1", pipe_stall);
    end
    pipe_flush = 1;
    #1;
    n_tests++;
    if (pipe_stall !== 1'b0 || issue !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: got stall=%b issue=%b want 0 0", pipe_stall, issue);
    end
    next_cycle();
    drive_idle();
    n_tests++;
    if (sb_pending !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL flush_keeps_sb: got sb=%h want 00000200", sb_pending);
    end
  endtask

  task automatic test_watchdog_and_reset();
    do_reset();
    present_long(5);
    next_cycle();
    present_read1(5);
    for (int i = 0; i < WDOG_MAX - 1; i++) next_cycle();
    n_tests++;
    if (stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_early: got tmo=%b after %0d stalls want 0", stall_timeout, WDOG_MAX - 1);
    end
    next_cycle();
    n_tests++;
    if (stall_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_fire: got tmo=%b after %0d stalls want 1", stall_timeout, WDOG_MAX);
    end
    drive_idle();
    next_cycle();
    next_cycle();
    n_tests++;
    if (stall_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_sticky: got tmo=%b want 1", stall_timeout);
    end
    dec_valid = 1; dec_div = 1;
    next_cycle();
    drive_idle();
    next_cycle();
    next_cycle();
    n_tests++;
    if (div_busy !== 1'b1 || sb_pending !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL pre_reset_state: got busy=%b sb=%h want 1 00000020", div_busy, sb_pending);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (div_busy !== 1'b0 || sb_pending !== 32'h0 || stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_div_reset: got busy=%b sb=%h tmo=%b want 0 00000000 0",
               div_busy, sb_pending, stall_timeout);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  // Randomized run against a reference model: a pending flag per register,
  // the cycle number of the last divider issue, and a saturating stall count.
  task automatic test_random(input int n_cycles);
    bit          pend [32];
    int          cyc, div_t, wdog;
    bit          tmo;
    bit          exp_busy, exp_stall, exp_issue, cand;
    logic [31:0] exp_sb;
    int          cands [$];
    do_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    cyc = 0; div_t = -1000; wdog = 0; tmo = 0;
    for (int c = 0; c < n_cycles; c++) begin
      dec_valid    = ($urandom_range(0, 9) < 8);
      dec_rs1_en   = $urandom_range(0, 1);
      dec_rs1_addr = 5'($urandom_range(0, 7));
      dec_rs2_en   = $urandom_range(0, 1);
      dec_rs2_addr = 5'($urandom_range(0, 7));
      dec_rd_en    = ($urandom_range(0, 3) != 0);
      dec_rd_addr  = 5'($urandom_range(0, 7));
      dec_long     = ($urandom_range(0, 9) < 3);
      dec_div      = ($urandom_range(0, 9) == 0);
      pipe_flush   = ($urandom_range(0, 19) == 0);
      wb_valid     = 0;
      wb_rd_addr   = 0;
      if ($urandom_range(0, 9) < 4) begin
        cands.delete();
        for (int r = 1; r < 32; r++) if (pend[r]) cands.push_back(r);
        wb_valid = 1;
        if (cands.size() > 0 && $urandom_range(0, 4) != 0)
          wb_rd_addr = 5'(cands[$urandom_range(0, cands.size() - 1)]);
        else
          wb_rd_addr = 5'($urandom_range(0, 31));
      end
      #1;
      exp_busy  = (cyc - div_t >= 1) && (cyc - div_t < DIV_LAT);
      cand      = dec_valid && !pipe_flush;
      exp_stall = cand && (
        (dec_rs1_en && dec_rs1_addr != 0 && pend[dec_rs1_addr] && !(wb_valid && wb_rd_addr == dec_rs1_addr)) ||
        (dec_rs2_en && dec_rs2_addr != 0 && pend[dec_rs2_addr] && !(wb_valid && wb_rd_addr == dec_rs2_addr)) ||
        (dec_rd_en  && dec_rd_addr  != 0 && pend[dec_rd_addr]  && !(wb_valid && wb_rd_addr == dec_rd_addr))  ||
        (dec_div && exp_busy));
      exp_issue = cand && !exp_stall;
      for (int r = 0; r < 32; r++) exp_sb[r] = pend[r];
      n_tests++;
      if (pipe_stall !== exp_stall || issue !== exp_issue || div_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got stall=%b issue=%b busy=%b want %b %b %b",
                 c, pipe_stall, issue, div_busy, exp_stall, exp_issue, exp_busy);
      end
      n_tests++;
      if (sb_pending !== exp_sb || stall_timeout !== tmo) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got sb=%h tmo=%b want %h %b",
                 c, sb_pending, stall_timeout, exp_sb, tmo);
      end
      next_cycle();
      if (wb_valid) pend[wb_rd_addr] = 0;
      if (exp_issue && dec_long && dec_rd_en && dec_rd_addr != 0) pend[dec_rd_addr] = 1;
      if (exp_issue && dec_div) div_t = cyc;
      if (exp_stall) begin
        if (wdog < WDOG_MAX) wdog++;
        if (wdog == WDOG_MAX) tmo = 1;
      end else begin
        wdog = 0;
      end
      cyc++;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_back_to_back_div();
    test_wb_and_set_same();
    test_flush();
    test_watchdog_and_reset();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
